// File: rtl/midi_rx_mmio.sv
// MIDI serial receiver with a byte FIFO and a two-register MMIO read port.
// Optional macro MIDI_REALTIME_FILTER_EN drops timing-clock (F8) and active-sensing (FE) bytes.
module midi_rx_mmio #(
  parameter int unsigned CLKS_PER_BIT = 1600,
  parameter int unsigned FIFO_LOG2    = 4,
  parameter logic [31:0] DATA_ADDR    = 32'h2002,
  parameter logic [31:0] STAT_ADDR    = 32'h2003
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        midi_rx,
  input  logic        mem_ren,
  input  logic [31:0] address_dmem,
  output logic        mmio_hit,
  output logic [31:0] mmio_result
);

  localparam int unsigned DEPTH = 2 ** FIFO_LOG2;
  localparam int unsigned CW    = $clog2(CLKS_PER_BIT);
  localparam int unsigned PW    = FIFO_LOG2;
  localparam int unsigned CNTW  = FIFO_LOG2 + 1;
  localparam int unsigned HALF  = CLKS_PER_BIT / 2;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_next;
  logic            rx_meta, rx_sync, rx_prev;
  logic [CW-1:0]   baud_cnt, baud_next;
  logic [2:0]      bit_cnt, bit_next;
  logic [7:0]      shreg, shreg_next;
  logic            push_req, push_next;
  logic            ferr_evt_c, keep_c;
  logic            ferr, ovf;
  logic [7:0]      mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CNTW-1:0] count;
  logic            data_sel_c, stat_sel_c, pop_c, full_c, do_push_c, ovf_set_c;

  // Synchronizer plus one extra stage for falling-edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= midi_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

`ifdef MIDI_REALTIME_FILTER_EN
  assign keep_c = (shreg != 8'hF8) && (shreg != 8'hFE);
`else
  assign keep_c = 1'b1;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      push_req <= 1'b0;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_cnt  <= bit_next;
      shreg    <= shreg_next;
      push_req <= push_next;
    end
  end

  // Edge detect on the synchronized line means a low line after a framing error
  // must go high again before a new start bit is recognised.
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_cnt;
    shreg_next = shreg;
    push_next  = 1'b0;
    ferr_evt_c = 1'b0;
    case (state)
      IDLE: begin
        baud_next = '0;
        bit_next  = '0;
        if (rx_prev && !rx_sync) state_next = START;
      end
      START: begin
        if (baud_cnt == CW'(HALF - 1)) begin
          baud_next  = '0;
          state_next = rx_sync ? IDLE : DATA;
        end else begin
          baud_next = baud_cnt + CW'(1);
        end
      end
      DATA: begin
        if (baud_cnt == CW'(CLKS_PER_BIT - 1)) begin
          baud_next  = '0;
          shreg_next = {rx_sync, shreg[7:1]};
          bit_next   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_next = STOP;
        end else begin
          baud_next = baud_cnt + CW'(1);
        end
      end
      STOP: begin
        if (baud_cnt == CW'(CLKS_PER_BIT - 1)) begin
          baud_next  = '0;
          state_next = IDLE;
          if (rx_sync) push_next  = keep_c;
          else         ferr_evt_c = 1'b1;
        end else begin
          baud_next = baud_cnt + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign data_sel_c = mem_ren && (address_dmem == DATA_ADDR);
  assign stat_sel_c = mem_ren && (address_dmem == STAT_ADDR);
  assign mmio_hit   = data_sel_c || stat_sel_c;
  assign pop_c      = data_sel_c && (count != '0);
  assign full_c     = (count == CNTW'(DEPTH));
  assign do_push_c  = push_req && (!full_c || pop_c);
  assign ovf_set_c  = push_req && full_c && !pop_c;

  always_comb begin
    mmio_result = '0;
    if (pop_c) begin
      mmio_result = {23'b0, 1'b1, mem[rd_ptr]};
    end else if (stat_sel_c) begin
      mmio_result[9]   = ferr;
      mmio_result[8]   = ovf;
      mmio_result[7:0] = 8'(count);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push_c) mem[wr_ptr] <= shreg;
  end

  // Pointers wrap naturally at the power-of-two depth; set events beat a status-read clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      ferr   <= 1'b0;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + PW'(1);
      if (pop_c)     rd_ptr <= rd_ptr + PW'(1);
      if (do_push_c && !pop_c)      count <= count + CNTW'(1);
      else if (!do_push_c && pop_c) count <= count - CNTW'(1);
      if (ovf_set_c)       ovf <= 1'b1;
      else if (stat_sel_c) ovf <= 1'b0;
      if (ferr_evt_c)      ferr <= 1'b1;
      else if (stat_sel_c) ferr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_midi_rx_mmio.sv
// Directed self-checking bench for midi_rx_mmio at CLKS_PER_BIT=16, FIFO_LOG2=2.
module tb_midi_rx_mmio;

  localparam int unsigned CPB = 16;
  localparam int unsigned FL  = 2;
  localparam logic [31:0] DA  = 32'h2002;
  localparam logic [31:0] SA  = 32'h2003;

  logic        clock = 1'b0;
  logic        reset;
  logic        midi_rx;
  logic        mem_ren;
  logic [31:0] address_dmem;
  logic        mmio_hit;
  logic [31:0] mmio_result;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  midi_rx_mmio #(
    .CLKS_PER_BIT(CPB),
    .FIFO_LOG2   (FL),
    .DATA_ADDR   (DA),
    .STAT_ADDR   (SA)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .midi_rx     (midi_rx),
    .mem_ren     (mem_ren),
    .address_dmem(address_dmem),
    .mmio_hit    (mmio_hit),
    .mmio_result (mmio_result)
  );

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic drive_bit(input logic v);
    midi_rx = v;
    wait_clks(CPB);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clock);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
    midi_rx = 1'b1;
    wait_clks(2 * CPB);
  endtask

  task automatic read_reg(input logic [31:0] a, output logic [31:0] d, output logic h);
    @(negedge clock);
    mem_ren      = 1'b1;
    address_dmem = a;
    #1;
    d = mmio_result;
    h = mmio_hit;
    @(posedge clock);
    #1;
    mem_ren      = 1'b0;
    address_dmem = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; midi_rx = 1'b1; mem_ren = 1'b0; address_dmem = '0;
    wait_clks(3);
    mem_ren = 1'b1; address_dmem = SA; #1;
    checks++;
    if (mmio_hit !== 1'b1 || mmio_result !== 32'h0) begin
      failures++; $display("FAIL reset_stat hit=%b got=%h exp hit=1 %h", mmio_hit, mmio_result, 32'h0);
    end
    address_dmem = DA; #1;
    checks++;
    if (mmio_hit !== 1'b1 || mmio_result !== 32'h0) begin
      failures++; $display("FAIL reset_data hit=%b got=%h exp hit=1 %h", mmio_hit, mmio_result, 32'h0);
    end
    address_dmem = 32'h2004; #1;
    checks++;
    if (mmio_hit !== 1'b0 || mmio_result !== 32'h0) begin
      failures++; $display("FAIL reset_miss hit=%b got=%h exp hit=0 %h", mmio_hit, mmio_result, 32'h0);
    end
    mem_ren = 1'b0; address_dmem = '0; #1;
    checks++;
    if (mmio_hit !== 1'b0) begin
      failures++; $display("FAIL reset_noren hit=%b exp=0", mmio_hit);
    end
    @(negedge clock);
    reset = 1'b0;
    wait_clks(4);
  endtask

  task automatic test_single();
    logic [31:0] d; logic h;
    send_byte(8'h90, 1'b1);
    read_reg(DA, d, h);
    checks++;
    if (d !== 32'h190 || h !== 1'b1) begin
      failures++; $display("FAIL single_data got=%h hit=%b exp=%h hit=1", d, h, 32'h190);
    end
    read_reg(DA, d, h);
    checks++;
    if (d !== 32'h0) begin
      failures++; $display("FAIL single_empty got=%h exp=%h", d, 32'h0);
    end
  endtask

  task automatic test_order();
    logic [31:0] d; logic h;
    logic [31:0] exp_w [3];
    exp_w = '{32'h190, 32'h13C, 32'h17F};
    send_byte(8'h90, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_byte(8'h7F, 1'b1);
    read_reg(SA, d, h);
    checks++;
    if (d !== 32'h3) begin
      failures++; $display("FAIL order_count got=%h exp=%h", d, 32'h3);
    end
    for (int i = 0; i < 3; i++) begin
      read_reg(DA, d, h);
      checks++;
      if (d !== exp_w[i]) begin
        failures++; $display("FAIL order_data%0d got=%h exp=%h", i, d, exp_w[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d; logic h;
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
    read_reg(SA, d, h);
    checks++;
    if (d !== 32'h104) begin
      failures++; $display("FAIL ovf_stat got=%h exp=%h", d, 32'h104);
    end
    read_reg(SA, d, h);
    checks++;
    if (d !== 32'h4) begin
      failures++; $display("FAIL ovf_cleared got=%h exp=%h", d, 32'h4);
    end
    for (int i = 1; i <= 4; i++) begin
      read_reg(DA, d, h);
      checks++;
      if (d !== (32'h100 | 32'(i))) begin
        failures++; $display("FAIL ovf_data%0d got=%h exp=%h", i, d, 32'h100 | 32'(i));
      end
    end
    read_reg(SA, d, h);
    checks++;
    if (d !== 32'h0) begin
      failures++; $display("FAIL ovf_drained got=%h exp=%h", d, 32'h0);
    end
  endtask

  task automatic test_ferr();
    logic [31:0] d; logic h;
    send_byte(8'hAA, 1'b0);
    read_reg(SA, d, h);
    checks++;
    if (d !== 32'h200) begin
      failures++; $display("FAIL ferr_stat got=%h exp=%h", d, 32'h200);
    end
    read_reg(SA, d, h);
    checks++;
    if (d !== 32'h0) begin
      failures++; $display("FAIL ferr_cleared got=%h exp=%h", d, 32'h0);
    end
  endtask

  task automatic test_glitch();
    logic [31:0] d; logic h;
    @(negedge clock);
    midi_rx = 1'b0;
    wait_clks(4);
    midi_rx = 1'b1;
    wait_clks(3 * CPB);
    read_reg(SA, d, h);
    checks++;
    if (d !== 32'h0) begin
      failures++; $display("FAIL glitch_stat got=%h exp=%h", d, 32'h0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    bytes = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 3; i++) send_byte(bytes[i], 1'b1);
    @(negedge clock);
    mem_ren = 1'b1; address_dmem = DA;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (mmio_result !== {24'h1, bytes[i]}) begin
        failures++; $display("FAIL b2b_data%0d got=%h exp=%h", i, mmio_result, {24'h1, bytes[i]});
      end
      @(negedge clock);
    end
    #1;
    checks++;
    if (mmio_result !== 32'h0 || mmio_hit !== 1'b1) begin
      failures++; $display("FAIL b2b_empty got=%h hit=%b exp=%h hit=1", mmio_result, mmio_hit, 32'h0);
    end
    mem_ren = 1'b0; address_dmem = '0;
  endtask

  task automatic test_filter();
    logic [31:0] d; logic h;
    send_byte(8'hF8, 1'b1);
    send_byte(8'h90, 1'b1);
    read_reg(SA, d, h);
`ifdef MIDI_REALTIME_FILTER_EN
    checks++;
    if (d !== 32'h1) begin
      failures++; $display("FAIL filter_count got=%h exp=%h", d, 32'h1);
    end
`else
    checks++;
    if (d !== 32'h2) begin
      failures++; $display("FAIL filter_count got=%h exp=%h", d, 32'h2);
    end
    read_reg(DA, d, h);
    checks++;
    if (d !== 32'h1F8) begin
      failures++; $display("FAIL filter_f8 got=%h exp=%h", d, 32'h1F8);
    end
`endif
    read_reg(DA, d, h);
    checks++;
    if (d !== 32'h190) begin
      failures++; $display("FAIL filter_data got=%h exp=%h", d, 32'h190);
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d; logic h;
    logic [7:0] b;
    b = 8'h55;
    @(negedge clock);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    midi_rx = b[4];
    wait_clks(CPB / 2);
    reset = 1'b1;
    midi_rx = 1'b1;
    wait_clks(3);
    reset = 1'b0;
    wait_clks(3 * CPB);
    send_byte(8'h66, 1'b1);
    read_reg(SA, d, h);
    checks++;
    if (d !== 32'h1) begin
      failures++; $display("FAIL midreset_count got=%h exp=%h", d, 32'h1);
    end
    read_reg(DA, d, h);
    checks++;
    if (d !== 32'h166) begin
      failures++; $display("FAIL midreset_data got=%h exp=%h", d, 32'h166);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_order();
    test_overflow();
    test_ferr();
    test_glitch();
    test_back_to_back();
    test_filter();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/midi_rx_mmio.md
MIDI_RX_MMIO -- requirements
Module: midi_rx_mmio

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 1600, giving clock cycles per MIDI bit (50 MHz / 31250 baud).
REQ-002 SHALL have parameter FIFO_LOG2, default 4, giving a receive FIFO depth of 2**FIFO_LOG2 bytes.
REQ-003 SHALL have parameter DATA_ADDR, default 32'h2002, the MMIO address of the pop/data register.
REQ-004 SHALL have parameter STAT_ADDR, default 32'h2003, the MMIO address of the status register.
REQ-005 SHALL have port clock, input, 1 bit, the single system clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit, asynchronous and active-high.
REQ-007 SHALL have port midi_rx, input, 1 bit, asynchronous serial MIDI line, idle high.
REQ-008 SHALL have port mem_ren, input, 1 bit, processor data-memory read enable.
REQ-009 SHALL have port address_dmem, input, 32 bits, processor data-memory address.
REQ-010 SHALL have port mmio_hit, output, 1 bit, high combinationally when mem_ren is high and address_dmem equals DATA_ADDR or STAT_ADDR.
REQ-011 SHALL have port mmio_result, output, 32 bits, combinational read data, and 32'h0 when mmio_hit is low.

Function
REQ-012 SHALL pass midi_rx through a two-flop synchronizer (reset value 1) before any use.
REQ-013 SHALL implement a receive FSM with states IDLE, START, DATA and STOP.
- IDLE -> START on a synchronized falling edge.
- START samples at CLKS_PER_BIT/2 cycles.
  - Low: go to DATA.
  - High: treat as a glitch and return to IDLE.
- DATA samples 8 bits, each CLKS_PER_BIT cycles apart, LSB first.
- STOP samples one CLKS_PER_BIT later, then returns to IDLE.
REQ-014 SHALL, when the stop bit samples high, push the byte into the FIFO in the cycle after the stop sample.
REQ-015 SHALL, when the stop bit samples low, discard the byte and set sticky flag ferr; the FSM SHALL then wait in IDLE for the line to return high before accepting a new falling edge.
REQ-016 SHALL, on a push into a full FIFO with no same-cycle pop, drop the new byte, leave the FIFO unchanged, and set sticky flag ovf.
REQ-017 SHALL, on a push and pop in the same cycle, perform both; a full FIFO then accepts the push and ovf is not set.
REQ-018 SHALL, for a read of DATA_ADDR with the FIFO non-empty, drive mmio_result = {23'b0, 1'b1, head_byte} and pop the head on that rising edge.
REQ-019 SHALL, for a read of DATA_ADDR with the FIFO empty, drive mmio_result = 32'h0 and not pop.
REQ-020 SHALL, for a read of STAT_ADDR, drive mmio_result = {22'b0, ferr, ovf, 3'b0, count}.
- count is FIFO_LOG2+1 bits, right-aligned.
- The field is zero-extended as needed.
REQ-021 SHALL clear ovf and ferr on the rising edge ending a STAT_ADDR read; a flag event in that same cycle SHALL win and leave the flag set.
REQ-022 SHALL wrap the FIFO read and write pointers modulo the depth; count SHALL range 0 to 2**FIFO_LOG2 inclusive.
REQ-023 SHALL count a mem_ren held high across N cycles at DATA_ADDR as N pops.

Reset
REQ-024 SHALL asynchronously set the FSM to IDLE on reset, and clear the bit counter, baud counter, pointers, count, ovf and ferr.
REQ-025 SHALL discard any partially received byte when reset is asserted mid-frame; after release, reception SHALL resume only on the next falling edge.
REQ-026 SHALL drive mmio_hit and mmio_result purely from inputs and state, so they read 0 status and an empty FIFO during reset.

Configuration
REQ-027 SHALL, when macro MIDI_REALTIME_FILTER_EN is defined, silently discard received bytes 8'hF8 (timing clock) and 8'hFE (active sensing): no push, no ovf.
REQ-028 SHALL, without MIDI_REALTIME_FILTER_EN, push every validly framed byte.

Verification (CLKS_PER_BIT=16, FIFO_LOG2=2)
REQ-029 SHALL cover single byte: send 8'h90 with a valid stop bit, then read DATA_ADDR -> mmio_result = 32'h190; the next read -> 32'h0.
REQ-030 SHALL cover ordering: send 8'h90, 8'h3C, 8'h7F, then read STAT_ADDR -> count 3 (32'h3), then three DATA_ADDR reads -> 32'h190, 32'h13C, 32'h17F.
REQ-031 SHALL cover overflow: send 5 bytes 8'h01-8'h05 without reading.
- STAT_ADDR read -> 32'h104 (ovf, count 4); the following STAT_ADDR read -> 32'h4.
- DATA_ADDR reads return bytes 01 to 04.
REQ-032 SHALL cover framing error: send 8'hAA with a low stop bit -> no push; STAT_ADDR read -> 32'h200.
REQ-033 SHALL cover reset mid-frame: assert reset during data bit 4 of 8'h55, release, then send 8'h66 -> FIFO holds only 8'h66 (DATA read -> 32'h166).
REQ-034 SHALL cover the filter: with MIDI_REALTIME_FILTER_EN defined, send 8'hF8, 8'h90 -> count 1 and DATA read -> 32'h190; without the macro -> count 2.
